// File: rtl/ssd_pkg.sv
// ssd_pkg: shared FSM encoding, counter sizing and two's complement helpers for the divider.
package ssd_pkg;
  typedef enum logic [2:0] {IDLE, PREP, ITER, FIX, DONE} state_e;
  // Helpers work on a wide word; callers sign/zero extend in and truncate out (WIDTH <= MAXW).
  localparam int MAXW = 64;
  function automatic int cnt_w(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction
  function automatic logic [MAXW-1:0] neg(input logic [MAXW-1:0] x);
    return -x;
  endfunction
  function automatic logic [MAXW-1:0] abs_v(input logic [MAXW-1:0] x);
    return x[MAXW-1] ? neg(x) : x;
  endfunction
endpackage

// File: rtl/shift_subtract_signed_divider_if.sv
// shift_subtract_signed_divider_if: start/done request and result bundle of the divider.
interface shift_subtract_signed_divider_if #(parameter int WIDTH = 8);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;
  modport master (output start, dividend, divisor,
                  input  busy, done, quotient, remainder, div_by_zero);
  modport slave  (input  start, dividend, divisor,
                  output busy, done, quotient, remainder, div_by_zero);
endinterface

// File: rtl/ssd_sub_stage.sv
// ssd_sub_stage: one restoring step -- subtract the divisor magnitude when it fits.
module ssd_sub_stage
  import ssd_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH:0] rem,
  input  logic [WIDTH:0] div_mag,
  output logic [WIDTH:0] next_rem,
  output logic           q_bit
);
  always_comb begin
    q_bit    = rem >= div_mag;
    next_rem = q_bit ? rem - div_mag : rem;
  end
endmodule

// File: rtl/shift_subtract_signed_divider.sv
// shift_subtract_signed_divider: iterative truncating signed divider, one quotient bit per clock.
// Define SSD_EARLY_TERM_EN to finish in PREP when |divisor| > |dividend|.
module shift_subtract_signed_divider
  import ssd_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input logic                          clk,
  input logic                          rst_n,
  shift_subtract_signed_divider_if.slave bus
);
`ifdef SSD_EARLY_TERM_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif
  localparam int CW = cnt_w(WIDTH);
  localparam logic [2:0] S_IDLE = IDLE;
  localparam logic [2:0] S_PREP = PREP;
  localparam logic [2:0] S_ITER = ITER;
  localparam logic [2:0] S_FIX  = FIX;
  localparam logic [2:0] S_DONE = DONE;

  logic [2:0]       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0] dmag_q, dmag_d, bmag_q, bmag_d, rem_q, rem_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] quo_q, quo_d, rmd_q, rmd_d;
  logic             dbz_q, dbz_d;
  logic [WIDTH-1:0] a_mag, b_mag, q_neg, r_neg;
  logic [WIDTH:0]   shifted, next_rem;
  logic             q_bit;

  // Magnitudes fit in WIDTH unsigned bits, including |-2^(W-1)|.
  assign a_mag   = WIDTH'(abs_v(MAXW'($signed(a_q))));
  assign b_mag   = WIDTH'(abs_v(MAXW'($signed(b_q))));
  assign q_neg   = WIDTH'(neg(MAXW'(dmag_q)));
  assign r_neg   = WIDTH'(neg(MAXW'(rem_q)));
  assign shifted = {rem_q, dmag_q[WIDTH-1]};

  ssd_sub_stage #(.WIDTH(WIDTH)) u_sub (
    .rem      (shifted),
    .div_mag  ({1'b0, bmag_q}),
    .next_rem (next_rem),
    .q_bit    (q_bit)
  );

  // The dividend register shifts out at the top and collects quotient bits at the bottom.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    dmag_d  = dmag_q;
    bmag_d  = bmag_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    quo_d   = quo_q;
    rmd_d   = rmd_q;
    dbz_d   = dbz_q;
    case (state_q)
      S_IDLE: if (bus.start) begin
        a_d     = bus.dividend;
        b_d     = bus.divisor;
        state_d = S_PREP;
      end
      S_PREP: begin
        dmag_d  = a_mag;
        bmag_d  = b_mag;
        rem_d   = '0;
        cnt_d   = CW'(WIDTH - 1);
        state_d = S_ITER;
        if (b_q == '0) begin
          quo_d   = '1;
          rmd_d   = a_q;
          dbz_d   = 1'b1;
          state_d = S_DONE;
        end else if (EARLY && b_mag > a_mag) begin
          quo_d   = '0;
          rmd_d   = a_q;
          dbz_d   = 1'b0;
          state_d = S_DONE;
        end
      end
      S_ITER: begin
        rem_d   = WIDTH'(next_rem);
        dmag_d  = {dmag_q[WIDTH-2:0], q_bit};
        cnt_d   = cnt_q - CW'(1);
        state_d = (cnt_q == '0) ? S_FIX : S_ITER;
      end
      S_FIX: begin
        quo_d   = (a_q[WIDTH-1] ^ b_q[WIDTH-1]) ? q_neg : dmag_q;
        rmd_d   = a_q[WIDTH-1] ? r_neg : rem_q;
        dbz_d   = 1'b0;
        state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      dmag_q  <= '0;
      bmag_q  <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      quo_q   <= '0;
      rmd_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      dmag_q  <= dmag_d;
      bmag_q  <= bmag_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      rmd_q   <= rmd_d;
      dbz_q   <= dbz_d;
    end
  end

  assign bus.busy        = (state_q == S_PREP) || (state_q == S_ITER) || (state_q == S_FIX);
  assign bus.done        = state_q == S_DONE;
  assign bus.quotient    = quo_q;
  assign bus.remainder   = rmd_q;
  assign bus.div_by_zero = dbz_q;
endmodule
